store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 st_valid  input  1  memory-stage store request (driven from MemWriteM).
REQ-007 st_addr  input  AW  store byte address (driven from ALUOutM).
REQ-008 st_data  input  DW  store data (driven from WriteDataM).
REQ-009 stall  output  1  buffer full; pipeline SHALL hold the store.
REQ-010 ld_addr  input  AW  load address for the forwarding lookup.
REQ-011 fwd_hit  output  1  a buffered store matches ld_addr.
REQ-012 fwd_data  output  DW  data of the youngest matching store.
REQ-013 bus_valid  output  1  head store offered to data memory.
REQ-014 bus_ready  input  1  data memory accepts the head store.
REQ-015 bus_addr  output  AW  head store address.
REQ-016 bus_data  output  DW  head store data.
REQ-017 empty  output  1  no stores pending.

Function
REQ-018 Circular FIFO of DEPTH entries {addr, data}; head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-019 Push occurs when st_valid && count<DEPTH; the entry is written at tail and tail increments.
REQ-020 Pop occurs when bus_valid && bus_ready; head increments.
REQ-021 Simultaneous push and pop leaves count unchanged; both pointers advance.
REQ-022 stall = (count==DEPTH), registered-state-derived only, independent of bus_ready; a push at count==DEPTH is not taken even if a pop occurs that cycle.
REQ-023 bus_valid = (count!=0); bus_addr/bus_data = head entry; these SHALL remain stable while bus_valid && !bus_ready.
REQ-024 Latency: a store pushed at edge N SHALL be offered as bus_valid from cycle N+1 if the buffer was empty.
REQ-025 empty = (count==0).
REQ-026 Forwarding is combinational: compare ld_addr[AW-1:2] against addr[AW-1:2] of every occupied entry; the youngest match (closest to tail) wins; fwd_hit=0 and fwd_data=0 when there is no match.
REQ-027 An entry popped in the current cycle still participates in forwarding that cycle; a store being pushed in the current cycle does not.
REQ-028 Stores are drained strictly in program order; no merging or reordering.

Reset
REQ-029 While reset=0: head=tail=0, count=0, stall=0, bus_valid=0, empty=1, fwd_hit=0; bus_addr/bus_data/fwd_data read 0.
REQ-030 Reset asserted mid-operation discards all pending stores immediately (asynchronously), including a head store offered but not yet accepted.
REQ-031 Entry storage arrays need not be reset; outputs SHALL be masked by occupancy.

Structure
REQ-032 Package store_buffer_pkg SHALL hold the DEPTH/AW/DW defaults and the packed entry struct sb_entry_t {addr, data}.
REQ-033 The youngest-match priority search SHALL be a sub-module sb_fwd_search (inputs: entries, occupancy mask, tail, ld_addr; outputs: hit, data).
REQ-034 No other sub-modules; storage and pointers are local flops in store_buffer.

Verification
REQ-035 Single store: st 0x100/0xDEADBEEF, bus_ready=1 -> bus_valid in next cycle with 0x100/0xDEADBEEF, empty=1 after one accept.
REQ-036 Fill: 4 stores with bus_ready=0 -> stall=1 after the 4th; 5th st_valid is not pushed; raise bus_ready -> drain order 1,2,3,4, then stall=0.
REQ-037 Forwarding: stores 0x40/0x11, 0x80/0x22, 0x40/0x33 buffered; ld_addr=0x42 -> fwd_hit=1, fwd_data=0x33; ld_addr=0xC0 -> fwd_hit=0.
REQ-038 Simultaneous push and pop at count=2 for 10 cycles -> count stays 2, pointers wrap past DEPTH, drain order preserved.
REQ-039 Backpressure: bus_ready=0 for 5 cycles -> bus_addr/bus_data constant throughout.
REQ-040 Reset mid-drain with count=3 -> bus_valid=0 and empty=1 without waiting for a clock edge; no further bus transactions after reset releases.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared defaults and the buffered-store entry type for the store buffer.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

    // One buffered store. Instances with narrower AW/DW zero-extend into
    // these fields, so AW <= SB_AW and DW <= SB_DW.
    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side store/load-forward port and memory-side drain port of the
// store buffer, bundled so the whole handshake travels as one port.
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int AW = SB_AW,
    parameter int DW = SB_DW
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          stall;
    logic [AW-1:0] ld_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          bus_valid;
    logic          bus_ready;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_data;
    logic          empty;

    // The store buffer itself.
    modport slave (
        input  st_valid, st_addr, st_data, ld_addr, bus_ready,
        output stall, fwd_hit, fwd_data, bus_valid, bus_addr, bus_data, empty
    );

    // The pipeline and data memory that talk to it.
    modport master (
        output st_valid, st_addr, st_data, ld_addr, bus_ready,
        input  stall, fwd_hit, fwd_data, bus_valid, bus_addr, bus_data, empty
    );
endinterface

// File: rtl/store_buffer_fwd_search.sv
// Youngest-match search over the buffered stores for load forwarding.
// Matching is on word address (bits [AW-1:2]); the entry closest to the
// tail pointer wins, and a miss returns zero data.
module sb_fwd_search
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW,
    parameter int PW    = $clog2(DEPTH)
)
(
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]      occ,
    input  logic [PW-1:0]         tail,
    input  logic [AW-1:0]         ld_addr,
    output logic                  hit,
    output logic [DW-1:0]         data
);

    logic [PW-1:0] idx_s;
    logic          unused_bits_s;

    // Walk from oldest to youngest so the youngest match is written last.
    always_comb begin
        hit   = 1'b0;
        data  = {DW{1'b0}};
        idx_s = {PW{1'b0}};
        for (int k = DEPTH; k >= 1; k--) begin
            idx_s = tail - PW'(k);
            if (occ[idx_s] && (entries[idx_s].addr[AW-1:2] == ld_addr[AW-1:2])) begin
                hit  = 1'b1;
                data = DW'(entries[idx_s].data);
            end else begin
                hit  = hit;
                data = data;
            end
        end
    end

    // Byte-offset bits take no part in the word-address compare.
    always_comb begin
        unused_bits_s = ^ld_addr[1:0];
        for (int i = 0; i < DEPTH; i++) begin
            unused_bits_s = unused_bits_s ^ (^entries[i].addr[1:0]);
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: a DEPTH-entry circular FIFO between the memory
// stage and data memory, with combinational load forwarding from the
// youngest matching pending store.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
)
(
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  sb
);

    localparam int             PW       = $clog2(DEPTH);
    localparam int             CW       = PW + 1;
    localparam logic [CW-1:0]  FULL     = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

    sb_entry_t [DEPTH-1:0] mem_r;
    logic [PW-1:0]         head_r;
    logic [PW-1:0]         tail_r;
    logic [CW-1:0]         count_r;

    logic                  full_s;
    logic                  nonempty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [PW-1:0]         rel_s;
    logic [DEPTH-1:0]      occ_s;
    logic                  fwd_hit_s;
    logic [DW-1:0]         fwd_data_s;

    // Full/empty come only from the registered count, so stall never
    // depends on bus_ready: a push at full is refused even if a pop happens.
    assign full_s     = (count_r == FULL);
    assign nonempty_s = (count_r != {CW{1'b0}});
    assign push_s     = sb.st_valid && !full_s;
    assign pop_s      = nonempty_s && sb.bus_ready;

    // Pointer and occupancy-count state; reset drops every pending store at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only ever observed through occupancy masks.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[tail_r] <= '{addr: SB_AW'(sb.st_addr), data: SB_DW'(sb.st_data)};
        end
    end

    // A slot is occupied when its distance from head is below the count.
    always_comb begin
        occ_s = {DEPTH{1'b0}};
        rel_s = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            rel_s    = PW'(i) - head_r;
            occ_s[i] = ({1'b0, rel_s} < count_r);
        end
    end

    sb_fwd_search #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .PW    (PW)
    ) u_fwd (
        .entries (mem_r),
        .occ     (occ_s),
        .tail    (tail_r),
        .ld_addr (sb.ld_addr),
        .hit     (fwd_hit_s),
        .data    (fwd_data_s)
    );

    // Status and head-of-queue outputs, with bus fields zeroed when nothing is pending.
    always_comb begin
        sb.stall     = full_s;
        sb.empty     = !nonempty_s;
        sb.bus_valid = nonempty_s;
        sb.fwd_hit   = fwd_hit_s;
        sb.fwd_data  = fwd_data_s;
        if (nonempty_s) begin
            sb.bus_addr = AW'(mem_r[head_r].addr);
            sb.bus_data = DW'(mem_r[head_r].data);
        end else begin
            sb.bus_addr = {AW{1'b0}};
            sb.bus_data = {DW{1'b0}};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a random
// run, all compared against a queue-based model of the pending stores.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_buffer_if #(.AW(32), .DW(32)) sbif();

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];

    // Youngest pending store whose word address matches.
    function automatic logic m_hit(input logic [31:0] la);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a[31:2] == la[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [31:0] la);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a[31:2] == la[31:2]) return mq[i].d;
        return 32'h0;
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic br, input logic [31:0] la);
        sbif.st_valid  = v;
        sbif.st_addr   = a;
        sbif.st_data   = d;
        sbif.bus_ready = br;
        sbif.ld_addr   = la;
        #2;
    endtask

    // One rising edge; the model applies pop then push using pre-edge occupancy.
    task automatic step();
        bit   do_pop;
        bit   do_push;
        ent_t e;
        do_pop  = (mq.size() != 0) && sbif.bus_ready;
        do_push = sbif.st_valid && (mq.size() < DEPTH);
        e.a = sbif.st_addr;
        e.d = sbif.st_data;
        @(posedge clk);
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 32'h123, 32'h456, 1'b1, 32'h120);
        mq.delete();
        total++; if (sbif.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", sbif.stall); end
        total++; if (sbif.bus_valid !== 1'b0) begin bad++; $display("FAIL reset_bus_valid got=%b want=0", sbif.bus_valid); end
        total++; if (sbif.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", sbif.empty); end
        total++; if (sbif.fwd_hit !== 1'b0) begin bad++; $display("FAIL reset_fwd_hit got=%b want=0", sbif.fwd_hit); end
        total++; if (sbif.fwd_data !== 32'h0) begin bad++; $display("FAIL reset_fwd_data got=%h want=0", sbif.fwd_data); end
        total++; if (sbif.bus_addr !== 32'h0) begin bad++; $display("FAIL reset_bus_addr got=%h want=0", sbif.bus_addr); end
        total++; if (sbif.bus_data !== 32'h0) begin bad++; $display("FAIL reset_bus_data got=%h want=0", sbif.bus_data); end
        @(posedge clk); #1;
        total++; if (sbif.empty !== 1'b1) begin bad++; $display("FAIL reset_held_empty got=%b want=1", sbif.empty); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_store();
        drive(1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        total++; if (sbif.bus_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", sbif.bus_valid); end
        total++; if (sbif.bus_addr !== 32'h100) begin bad++; $display("FAIL single_addr got=%h want=100", sbif.bus_addr); end
        total++; if (sbif.bus_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h want=deadbeef", sbif.bus_data); end
        total++; if (sbif.empty !== 1'b0) begin bad++; $display("FAIL single_notempty got=%b want=0", sbif.empty); end
        step();
        total++; if (sbif.empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b want=1", sbif.empty); end
        total++; if (sbif.bus_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b want=0", sbif.bus_valid); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(32'h200 + i * 16), 32'(i + 1), 1'b0, 32'h0);
            step();
        end
        total++; if (sbif.stall !== 1'b1) begin bad++; $display("FAIL fill_stall got=%b want=1", sbif.stall); end
        drive(1'b1, 32'h300, 32'hBAD, 1'b0, 32'h0);
        step();
        total++; if (sbif.stall !== 1'b1) begin bad++; $display("FAIL fill_5th_stall got=%b want=1", sbif.stall); end
        // Full with a pop this cycle: stall stays up and the offered store is refused.
        drive(1'b1, 32'h300, 32'hBAD, 1'b1, 32'h0);
        total++; if (sbif.stall !== 1'b1) begin bad++; $display("FAIL fill_stall_ready got=%b want=1", sbif.stall); end
        total++; if (sbif.bus_data !== 32'h1) begin bad++; $display("FAIL fill_drain1 got=%h want=1", sbif.bus_data); end
        step();
        for (int k = 2; k <= 4; k++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
            total++; if (sbif.stall !== 1'b0) begin bad++; $display("FAIL fill_unstall%0d got=%b want=0", k, sbif.stall); end
            total++; if (sbif.bus_data !== 32'(k)) begin bad++; $display("FAIL fill_drain%0d got=%h want=%h", k, sbif.bus_data, k); end
            total++; if (sbif.bus_addr !== 32'(32'h200 + (k - 1) * 16)) begin bad++; $display("FAIL fill_addr%0d got=%h", k, sbif.bus_addr); end
            step();
        end
        total++; if (sbif.empty !== 1'b1) begin bad++; $display("FAIL fill_empty got=%b want=1 (refused store leaked?)", sbif.empty); end
    endtask

    task automatic test_forwarding();
        drive(1'b1, 32'h40, 32'h11, 1'b0, 32'h0); step();
        drive(1'b1, 32'h80, 32'h22, 1'b0, 32'h0); step();
        drive(1'b1, 32'h40, 32'h33, 1'b0, 32'h0); step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h42);
        total++; if (sbif.fwd_hit !== 1'b1) begin bad++; $display("FAIL fwd_42_hit got=%b want=1", sbif.fwd_hit); end
        total++; if (sbif.fwd_data !== 32'h33) begin bad++; $display("FAIL fwd_42_data got=%h want=33", sbif.fwd_data); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'hC0);
        total++; if (sbif.fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_c0_hit got=%b want=0", sbif.fwd_hit); end
        total++; if (sbif.fwd_data !== 32'h0) begin bad++; $display("FAIL fwd_c0_data got=%h want=0", sbif.fwd_data); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h83);
        total++; if (sbif.fwd_data !== 32'h22) begin bad++; $display("FAIL fwd_83_data got=%h want=22", sbif.fwd_data); end
        // A store entering this cycle is not yet visible to forwarding.
        drive(1'b1, 32'hC0, 32'h44, 1'b0, 32'hC0);
        total++; if (sbif.fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_inflight got=%b want=0", sbif.fwd_hit); end
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'hC1);
        total++; if (sbif.fwd_data !== 32'h44) begin bad++; $display("FAIL fwd_c1_data got=%h want=44", sbif.fwd_data); end
        // Drain while looking up 0x40; the entry being popped still forwards.
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
            total++; if (sbif.fwd_hit !== m_hit(32'h40)) begin bad++; $display("FAIL fwd_drain%0d_hit got=%b want=%b", k, sbif.fwd_hit, m_hit(32'h40)); end
            total++; if (sbif.fwd_data !== m_fwd(32'h40)) begin bad++; $display("FAIL fwd_drain%0d_data got=%h want=%h", k, sbif.fwd_data, m_fwd(32'h40)); end
            step();
        end
    endtask

    task automatic test_push_pop_wrap();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'(32'h500 + i * 4), $urandom, 1'b0, 32'h0);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(32'h600 + i * 4), $urandom, 1'b1, 32'h0);
            total++; if (sbif.stall !== 1'b0 || sbif.bus_valid !== 1'b1) begin bad++; $display("FAIL wrap%0d_status stall=%b valid=%b want 0/1", i, sbif.stall, sbif.bus_valid); end
            total++; if (sbif.bus_addr !== mq[0].a || sbif.bus_data !== mq[0].d) begin bad++; $display("FAIL wrap%0d_head got=%h/%h want=%h/%h", i, sbif.bus_addr, sbif.bus_data, mq[0].a, mq[0].d); end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
            total++; if (sbif.bus_addr !== 32'(32'h600 + (8 + i) * 4) || sbif.bus_data !== mq[0].d) begin bad++; $display("FAIL wrap_tail%0d got=%h/%h want=%h/%h", i, sbif.bus_addr, sbif.bus_data, 32'h600 + (8 + i) * 4, mq[0].d); end
            step();
        end
        total++; if (sbif.empty !== 1'b1) begin bad++; $display("FAIL wrap_count got_empty=%b want=1", sbif.empty); end
    endtask

    task automatic test_backpressure();
        logic [31:0] a0;
        logic [31:0] d0;
        a0 = 32'h700;
        d0 = $urandom;
        drive(1'b1, a0, d0, 1'b0, 32'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(32'h710 + i * 4), $urandom, 1'b0, 32'h0);
            total++; if (sbif.bus_addr !== a0 || sbif.bus_data !== d0) begin bad++; $display("FAIL bp%0d got=%h/%h want=%h/%h", i, sbif.bus_addr, sbif.bus_data, a0, d0); end
            step();
        end
        for (int k = 0; k < DEPTH + 1 && mq.size() != 0; k++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
            total++; if (sbif.bus_addr !== mq[0].a) begin bad++; $display("FAIL bp_drain%0d got=%h want=%h", k, sbif.bus_addr, mq[0].a); end
            step();
        end
        total++; if (sbif.empty !== 1'b1) begin bad++; $display("FAIL bp_empty got=%b want=1", sbif.empty); end
    endtask

    task automatic test_random();
        logic [31:0] la;
        for (int c = 0; c < 400; c++) begin
            la = 32'(32'h1000 + $urandom_range(0, 9) * 4 + $urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), 32'(32'h1000 + $urandom_range(0, 7) * 4),
                  $urandom, 1'($urandom_range(0, 9) < 6), la);
            total++; if (sbif.stall !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd%0d_stall got=%b", c, sbif.stall); end
            total++; if (sbif.empty !== (mq.size() == 0) || sbif.bus_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd%0d_occ empty=%b valid=%b size=%0d", c, sbif.empty, sbif.bus_valid, mq.size()); end
            if (mq.size() != 0) begin
                total++; if (sbif.bus_addr !== mq[0].a || sbif.bus_data !== mq[0].d) begin bad++; $display("FAIL rnd%0d_head got=%h/%h want=%h/%h", c, sbif.bus_addr, sbif.bus_data, mq[0].a, mq[0].d); end
            end else begin
                total++; if (sbif.bus_addr !== 32'h0 || sbif.bus_data !== 32'h0) begin bad++; $display("FAIL rnd%0d_idle got=%h/%h want=0/0", c, sbif.bus_addr, sbif.bus_data); end
            end
            total++; if (sbif.fwd_hit !== m_hit(la) || sbif.fwd_data !== m_fwd(la)) begin bad++; $display("FAIL rnd%0d_fwd got=%b/%h want=%b/%h", c, sbif.fwd_hit, sbif.fwd_data, m_hit(la), m_fwd(la)); end
            step();
        end
        for (int k = 0; k < DEPTH + 1 && mq.size() != 0; k++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
            step();
        end
        total++; if (sbif.empty !== 1'b1) begin bad++; $display("FAIL rnd_final_empty got=%b want=1", sbif.empty); end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(32'h900 + i * 4), 32'(32'hA0 + i), 1'b0, 32'h0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h900);
        total++; if (sbif.bus_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", sbif.bus_valid); end
        reset = 1'b0;
        #1;
        mq.delete();
        total++; if (sbif.bus_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b want=0", sbif.bus_valid); end
        total++; if (sbif.empty !== 1'b1) begin bad++; $display("FAIL mid_async_empty got=%b want=1", sbif.empty); end
        total++; if (sbif.fwd_hit !== 1'b0) begin bad++; $display("FAIL mid_async_fwd got=%b want=0", sbif.fwd_hit); end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h900);
            total++; if (sbif.bus_valid !== 1'b0) begin bad++; $display("FAIL mid_post%0d_valid got=%b want=0", i, sbif.bus_valid); end
            step();
        end
    endtask

    initial begin
        reset          = 1'b0;
        sbif.st_valid  = 1'b0;
        sbif.st_addr   = 32'h0;
        sbif.st_data   = 32'h0;
        sbif.bus_ready = 1'b0;
        sbif.ld_addr   = 32'h0;
        #1;
        test_reset();
        test_single_store();
        test_fill();
        test_forwarding();
        test_push_pop_wrap();
        test_backpressure();
        test_random();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
